f_to_bcd_display: RTL

//  Downstream consumer of the Celsius-to-Fahrenheit datapath: accepts its 7-bit binary Fahrenheit result.

---
 rtl/f_to_bcd_display_if.sv | 45 ++++
 rtl/f_to_bcd_display.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/f_to_bcd_display_if.sv
// Handshake and display bundle between the Fahrenheit producer and the BCD display block.
// The master drives the binary value and its valid strobe. The slave returns
// readiness, status, the held BCD digits and the multiplexed segment drive.
interface f_to_bcd_display_if #(
    parameter int unsigned W_IN = 7
) ();

    logic [W_IN-1:0] f;
    logic            in_valid;
    logic            in_ready;
    logic            busy;
    logic            out_valid;
    logic [3:0]      bcd_h;
    logic [3:0]      bcd_t;
    logic [3:0]      bcd_o;
    logic [2:0]      digit_sel;
    logic [6:0]      seg;

    modport master (
        output f,
        output in_valid,
        input  in_ready,
        input  busy,
        input  out_valid,
        input  bcd_h,
        input  bcd_t,
        input  bcd_o,
        input  digit_sel,
        input  seg
    );

    modport slave (
        input  f,
        input  in_valid,
        output in_ready,
        output busy,
        output out_valid,
        output bcd_h,
        output bcd_t,
        output bcd_o,
        output digit_sel,
        output seg
    );

endinterface

// File: rtl/f_to_bcd_display.sv
// Binary-to-BCD converter with a 3-digit multiplexed seven-segment driver.
// A W_IN-bit unsigned value is accepted on a valid/ready handshake. It is converted
// with a sequential shift-add-3 (double-dabble) loop, one bit per cycle. The last
// result is held and scanned onto a time-multiplexed 3-digit display.
module f_to_bcd_display #(
    parameter int unsigned W_IN     = 7,
    parameter int unsigned SCAN_DIV = 4
) (
    input logic                    clk,
    input logic                    rst,
    f_to_bcd_display_if.slave      bus
);

    localparam int unsigned     CntW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
    localparam logic [3:0]      LastIter = 4'(W_IN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_next;

    logic [W_IN-1:0]     r_bin_sr;
    logic [11:0]         r_bcd_sr;
    logic [3:0]          r_iter;

    logic [3:0]          r_bcd_h;
    logic [3:0]          r_bcd_t;
    logic [3:0]          r_bcd_o;

    logic [CntW-1:0]     r_scan_cnt;
    logic [2:0]          r_digit_sel;

    logic                w_in_ready;
    logic                w_busy;
    logic                w_out_valid;
    logic                w_accept;
    logic                w_last_shift;

    logic [11:0]         w_bcd_adj;
    logic [W_IN+11:0]    w_shift;
    logic [11:0]         w_shift_bcd;

    logic [3:0]          w_digit;
    logic                w_blank;
    logic [6:0]          w_seg;

    // Seven-segment pattern for one decimal digit; non-decimal codes stay dark.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one shift cycle per input bit, then a single DONE cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_state_next = StShift;
                end
            end
            StShift: begin
                if (r_iter == LastIter) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // FSM outputs, all decoded from the current state.
    always_comb begin
        w_in_ready   = (r_state == StIdle);
        w_busy       = (r_state != StIdle);
        w_out_valid  = (r_state == StDone);
        w_accept     = w_in_ready && bus.in_valid;
        w_last_shift = (r_state == StShift) && (r_iter == LastIter);
    end

    // One double-dabble step: correct each BCD nibble, then shift the whole chain left.
    always_comb begin
        w_bcd_adj = r_bcd_sr;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd_sr[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd_sr[4*i +: 4] + 4'd3;
            end
        end
        w_shift     = {w_bcd_adj, r_bin_sr} << 1;
        w_shift_bcd = w_shift[W_IN +: 12];
    end

    // Conversion shift registers and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin_sr <= '0;
            r_bcd_sr <= '0;
            r_iter   <= '0;
        end else if (w_accept) begin
            r_bin_sr <= bus.f;
            r_bcd_sr <= '0;
            r_iter   <= '0;
        end else if (r_state == StShift) begin
            r_bin_sr <= w_shift[W_IN-1:0];
            r_bcd_sr <= w_shift_bcd;
            r_iter   <= r_iter + 4'd1;
        end
    end

    // Held result: captured on the final shift so the digits are already valid
    // during the out_valid cycle, and untouched while a conversion is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd_h <= '0;
            r_bcd_t <= '0;
            r_bcd_o <= '0;
        end else if (w_last_shift) begin
            r_bcd_h <= w_shift_bcd[11:8];
            r_bcd_t <= w_shift_bcd[7:4];
            r_bcd_o <= w_shift_bcd[3:0];
        end
    end

    // Free-running scan divider; each wrap rotates the one-hot digit select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= 3'b001;
        end else if (r_scan_cnt == CntMax) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= {r_digit_sel[1:0], r_digit_sel[2]};
        end else begin
            r_scan_cnt  <= r_scan_cnt + 1'b1;
        end
    end

    // Segment drive for the selected digit, with leading-zero blanking.
    always_comb begin
        w_digit = r_bcd_o;
        w_blank = 1'b0;
        unique case (r_digit_sel)
            3'b001: begin
                w_digit = r_bcd_o;
            end
            3'b010: begin
                w_digit = r_bcd_t;
                w_blank = (r_bcd_h == 4'd0) && (r_bcd_t == 4'd0);
            end
            3'b100: begin
                w_digit = r_bcd_h;
                w_blank = (r_bcd_h == 4'd0);
            end
            default: begin
                w_digit = r_bcd_o;
            end
        endcase
        w_seg = w_blank ? 7'h00 : seg_of(w_digit);
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = w_out_valid;
    assign bus.bcd_h     = r_bcd_h;
    assign bus.bcd_t     = r_bcd_t;
    assign bus.bcd_o     = r_bcd_o;
    assign bus.digit_sel = r_digit_sel;
    assign bus.seg       = w_seg;

endmodule
